selten_fetch_queue: RTL

SELTEN_FETCH_QUEUE -- requirements
Module: selten_fetch_queue

---
 rtl/selten_pkg.sv | 13 +
 rtl/selten_sync_fifo.sv | 43 ++++
 rtl/selten_fetch_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/selten_pkg.sv
// selten_pkg: shared XLEN, instruction-field slices and fetch FSM states
package selten_pkg;
  localparam int XLEN    = 19;
  localparam int OPC_MSB = 18;
  localparam int OPC_LSB = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_FLUSH} fetch_state_e;
endpackage

// File: rtl/selten_sync_fifo.sv
// selten_sync_fifo: synchronous FIFO with push/pop/flush and occupancy count
// Ports: clk, rst (sync active-high), push_i/data_i write, pop_i removes head,
//        flush_i empties, data_o head entry, count_o occupancy, empty_o.
module selten_sync_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign do_push = push_i && (count_q != CW'(DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
endmodule

// File: rtl/selten_fetch_queue.sv
// selten_fetch_queue: instruction prefetch queue with redirect flush
// Ports: clk, RN (sync active-high reset); imem_req_* request channel;
//        imem_rsp_* in-order responses; redirect_valid/redirect_pc restart;
//        if_valid/if_ready/if_ir/if_npc decode handshake.
// Optional: define SELTEN_FETCH_BYPASS_EN to forward a response straight to
//           decode when the queue is empty and decode is ready.
module selten_fetch_queue
  import selten_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 19'd0
) (
  input  logic            clk,
  input  logic            RN,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_ir,
  output logic [XLEN-1:0] if_npc
);
  localparam int CW = $clog2(DEPTH+1);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rsp_npc;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, in_fl, fifo_count;
  logic [2*XLEN-1:0] head;
  logic hs, push, pop, flush, fifo_empty, bypass, run, redir;
  assign run   = state_q == FS_RUN && !RN;
  assign redir = redirect_valid && state_q != FS_BOOT;
  assign imem_req_valid = run && out_q < CW'(MAX_OUT) &&
                          ({1'b0, fifo_count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign imem_req_addr  = pc_q;
  assign hs = imem_req_valid && imem_req_ready;
  // In RUN every in-flight request is consecutive and ends at pc-1
  assign rsp_npc = pc_q - XLEN'(out_q) + XLEN'(1);
`ifdef SELTEN_FETCH_BYPASS_EN
  assign bypass = run && imem_rsp_valid && fifo_empty && if_ready && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  assign push  = run && imem_rsp_valid && !redirect_valid && !bypass;
  assign flush = redir;
  assign pop   = !fifo_empty && if_ready && !flush;
  selten_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (RN),
    .push_i  (push),
    .data_i  ({imem_rsp_data, rsp_npc}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );
  assign if_valid = !RN && (!fifo_empty || bypass);
  assign if_ir    = bypass ? imem_rsp_data : (if_valid ? head[2*XLEN-1:XLEN] : '0);
  assign if_npc   = bypass ? rsp_npc : (if_valid ? head[XLEN-1:0] : '0);
  // Requests still owed a response after this edge; in FLUSH they are all stale
  assign in_fl = state_q == FS_RUN ? out_q + CW'(hs) - CW'(imem_rsp_valid)
                                   : disc_q - CW'(imem_rsp_valid);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    disc_d  = disc_q;
    if (state_q == FS_BOOT) begin
      state_d = FS_RUN;
    end else begin
      pc_d    = redirect_valid ? redirect_pc : pc_q + XLEN'(hs);
      out_d   = (state_q == FS_RUN && !redirect_valid) ? in_fl : '0;
      disc_d  = (state_q == FS_FLUSH || redirect_valid) ? in_fl : '0;
      state_d = (state_q == FS_FLUSH || redirect_valid) && in_fl != '0 ? FS_FLUSH : FS_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (RN) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end
endmodule
